// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: serial pin, received-byte handshake and status pulses of the UART receiver
interface uart_rx_byte_if;
  logic       uart_rxd;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;
  modport master (input uart_rxd, i_ready, output o_data, o_valid, o_frame_err, o_overrun, o_busy);
  modport slave (output uart_rxd, i_ready, input o_data, o_valid, o_frame_err, o_overrun, o_busy);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 LSB-first UART receiver with a one-entry valid/ready holding register
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 1157,
  parameter int SYNC_STAGES  = 2
) (
  input logic          clk,
  input logic          rst,
  uart_rx_byte_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [2:0]             r_bit, w_bit_nxt;
  logic [7:0]             r_shift, w_shift_nxt, r_data;
  logic                   r_valid, r_frame_err, r_overrun;
  logic                   w_rx, w_tick, w_deliver, w_frame_err;
  assign w_rx            = r_sync[SYNC_STAGES-1];
  assign bus.o_data      = r_data;
  assign bus.o_valid     = r_valid;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_overrun   = r_overrun;
  assign bus.o_busy      = r_state != IDLE;
  // bring the asynchronous pin into the clock domain; reset to the idle-high level
  always_ff @(posedge clk)
    r_sync <= rst ? '1 : {r_sync[SYNC_STAGES-2:0], bus.uart_rxd};
  // bit timing and frame sequencing: first sample mid start bit, then once per bit period
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_frame_err = 1'b0;
    w_tick      = r_cnt == (r_state == START ? HALF_LAST : BIT_LAST);
    w_cnt_nxt   = (r_state == IDLE || r_state == BRK || w_tick) ? '0 : r_cnt + CW'(1);
    case (r_state)
      IDLE:  if (!w_rx) w_state_nxt = START;
      START: if (w_tick) begin
        w_state_nxt = w_rx ? IDLE : DATA;
        w_bit_nxt   = '0;
      end
      DATA:  if (w_tick) begin
        w_shift_nxt = {w_rx, r_shift[7:1]};
        w_bit_nxt   = r_bit + 3'd1;
        w_state_nxt = r_bit == 3'd7 ? STOP : DATA;
      end
      STOP:  if (w_tick) begin
        w_deliver   = w_rx;
        w_frame_err = !w_rx;
        w_state_nxt = w_rx ? IDLE : BRK;
      end
      BRK:   if (w_rx) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // frame state, bit-period counter, bit index and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end
  // holding register: a pop and a delivery in the same cycle refill it; a delivery into a full register is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_deliver && r_valid && !bus.i_ready;
      if (w_deliver && (!r_valid || bus.i_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && bus.i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule
